// File: rtl/seg_msg_sequencer.sv
// seg_msg_sequencer: index/load/blank controller for the seven-segment
// message datapath (debounced manual step or timed auto-scroll).
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   step_btn        raw asynchronous step button (active high)
//   auto_en         1 = auto-scroll, 0 = manual stepping
//   dir             0 = forward (idx+1), 1 = reverse (idx-1)
//   rate_sel[1:0]   auto period = TICK_DIV >> rate_sel
//   char_idx[3:0]   current character index, 0..MSG_LEN-1
//   char_load       one-cycle strobe: glyph stage loads char_idx
//   blank           1 = segments forced off
//   wrap            one-cycle pulse with char_load when the index wrapped
//   holding         1 while auto-scroll is paused
module seg_msg_sequencer #(
    parameter int unsigned MSG_LEN  = 14,
    parameter int unsigned DEBOUNCE = 20000,
    parameter int unsigned TICK_DIV = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       step_btn,
    input  logic       auto_en,
    input  logic       dir,
    input  logic [1:0] rate_sel,
    output logic [3:0] char_idx,
    output logic       char_load,
    output logic       blank,
    output logic       wrap,
    output logic       holding
);

    localparam int unsigned DB_W  = $clog2(DEBOUNCE + 1);
    localparam int unsigned PRE_W = $clog2(TICK_DIV + 1);

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE - 1);
    localparam logic [PRE_W-1:0] PRE_FULL = PRE_W'(TICK_DIV);
    localparam logic [3:0]       LAST_IDX = 4'(MSG_LEN - 1);

    typedef enum logic [1:0] {
        S_BLANK = 2'd0,
        S_RUN   = 2'd1,
        S_HOLD  = 2'd2
    } state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             db_level_q, db_level_d;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic             step_q, step_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    state_e           state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic             load_q, load_d;
    logic             wrap_q, wrap_d;
    logic             blank_q, blank_d;
    logic             hold_q, hold_d;

    // ------------------------------------------------------------------
    // Button path: 2-FF synchronizer, then a stability counter. The
    // debounced level only moves after DEBOUNCE consecutive samples that
    // disagree with it; any agreeing sample restarts the count.
    // ------------------------------------------------------------------
    always_comb begin
        sync1_d    = step_btn;
        sync2_d    = sync1_q;
        db_level_d = db_level_q;
        db_cnt_d   = '0;
        step_d     = 1'b0;
        if (sync2_q != db_level_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_level_d = sync2_q;
                // Registered rising-edge pulse of the debounced level.
                step_d     = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Prescaler tick. Comparing with >= lets a switch to a shorter period
    // fire on the next cycle instead of waiting for the counter to wrap.
    // ------------------------------------------------------------------
    logic [PRE_W-1:0] period;
    logic             auto_run;
    logic             tick;

    always_comb begin
        period   = PRE_FULL >> rate_sel;
        auto_run = (state_q == S_RUN) && auto_en;
        tick     = auto_run && (pre_q >= (period - PRE_W'(1)));
    end

    // ------------------------------------------------------------------
    // Next index for an advance in the current direction.
    // ------------------------------------------------------------------
    logic [3:0] adv_idx;
    logic       adv_wrap;

    always_comb begin
        adv_idx  = idx_q;
        adv_wrap = 1'b0;
        if (dir) begin
            if (idx_q == 4'd0) begin
                adv_idx  = LAST_IDX;
                adv_wrap = 1'b1;
            end else begin
                adv_idx = idx_q - 4'd1;
            end
        end else begin
            if (idx_q >= LAST_IDX) begin
                adv_idx  = 4'd0;
                adv_wrap = 1'b1;
            end else begin
                adv_idx = idx_q + 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM: next state and registered outputs.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        load_d  = 1'b0;
        wrap_d  = 1'b0;
        pre_d   = '0;

        unique case (state_q)
            S_BLANK: begin
                if (step_q || auto_en) begin
                    state_d = S_RUN;
                    idx_d   = 4'd0;
                    load_d  = 1'b1;
                end
            end
            S_RUN: begin
                if (!auto_en) begin
                    if (step_q) begin
                        idx_d  = adv_idx;
                        wrap_d = adv_wrap;
                        load_d = 1'b1;
                    end
                end else if (step_q) begin
                    // Pause wins over a same-cycle tick; the count restarts.
                    state_d = S_HOLD;
                end else if (tick) begin
                    idx_d  = adv_idx;
                    wrap_d = adv_wrap;
                    load_d = 1'b1;
                end else begin
                    pre_d = pre_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (step_q || !auto_en) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_BLANK;
                idx_d   = 4'd0;
            end
        endcase

        blank_d = (state_d == S_BLANK);
        hold_d  = (state_d == S_HOLD);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            db_level_q <= 1'b0;
            db_cnt_q   <= '0;
            step_q     <= 1'b0;
            pre_q      <= '0;
            state_q    <= S_BLANK;
            idx_q      <= 4'd0;
            load_q     <= 1'b0;
            wrap_q     <= 1'b0;
            blank_q    <= 1'b1;
            hold_q     <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            db_level_q <= db_level_d;
            db_cnt_q   <= db_cnt_d;
            step_q     <= step_d;
            pre_q      <= pre_d;
            state_q    <= state_d;
            idx_q      <= idx_d;
            load_q     <= load_d;
            wrap_q     <= wrap_d;
            blank_q    <= blank_d;
            hold_q     <= hold_d;
        end
    end

    assign char_idx  = idx_q;
    assign char_load = load_q;
    assign blank     = blank_q;
    assign wrap      = wrap_q;
    assign holding   = hold_q;

endmodule

// File: tb/tb_seg_msg_sequencer.sv
// Testbench for seg_msg_sequencer: directed stimulus, scoreboard of
// expected load events checked by an independent monitor.
module tb_seg_msg_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       step_btn;
    logic       auto_en;
    logic       dir;
    logic [1:0] rate_sel;
    logic [3:0] char_idx;
    logic       char_load;
    logic       blank;
    logic       wrap;
    logic       holding;

    seg_msg_sequencer #(
        .MSG_LEN (14),
        .DEBOUNCE(4),
        .TICK_DIV(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .step_btn (step_btn),
        .auto_en  (auto_en),
        .dir      (dir),
        .rate_sel (rate_sel),
        .char_idx (char_idx),
        .char_load(char_load),
        .blank    (blank),
        .wrap     (wrap),
        .holding  (holding)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int idx;
        int wrp;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push(input int idx, input int wrp, input int at);
        exp_t e;
        e.idx = idx;
        e.wrp = wrp;
        e.cyc = at;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (cyc %0d)",
                     name, act, req, cyc);
        end
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Monitor: every char_load must match the oldest expectation exactly,
    // including the cycle on which it appears.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (char_load === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_load: got idx=%0d at cyc %0d, required no load",
                             char_idx, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (char_idx !== 4'(e.idx) || wrap !== 1'(e.wrp) ||
                        cyc != e.cyc || blank !== 1'b0 || holding !== 1'b0) begin
                        errors++;
                        $display("FAIL load: got idx=%0d wrap=%0d cyc=%0d blank=%0d hold=%0d, required idx=%0d wrap=%0d cyc=%0d blank=0 hold=0",
                                 char_idx, wrap, cyc, blank, holding,
                                 e.idx, e.wrp, e.cyc);
                    end
                end
            end else if (wrap === 1'b1) begin
                checks++;
                errors++;
                $display("FAIL wrap_no_load: got wrap=1 at cyc %0d, required wrap=0", cyc);
            end
        end
    end

    task automatic do_reset();
        rst      = 1'b1;
        step_btn = 1'b0;
        auto_en  = 1'b0;
        dir      = 1'b0;
        rate_sel = 2'd0;
        repeat (2) @(negedge clk);
        chk("rst_blank", int'(blank), 1);
        chk("rst_idx", int'(char_idx), 0);
        chk("rst_load", int'(char_load), 0);
        chk("rst_wrap", int'(wrap), 0);
        chk("rst_hold", int'(holding), 0);
        rst = 1'b0;
    endtask

    // Clean press: first sampled at the next edge, load DEBOUNCE+3 = 7
    // negedges later; the button is then released and allowed to settle.
    task automatic press(input int idx, input int wrp);
        push(idx, wrp, cyc + 7);
        step_btn = 1'b1;
        repeat (8) @(negedge clk);
        step_btn = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        int c;
        int p;
        rst      = 1'b1;
        step_btn = 1'b0;
        auto_en  = 1'b0;
        dir      = 1'b0;
        rate_sel = 2'd0;

        // 1: debounce latency and a second press
        do_reset();
        press(0, 0);
        chk("t1_blank", int'(blank), 0);
        press(1, 0);
        chk("t1_idx", int'(char_idx), 1);

        // 2: bounces shorter than DEBOUNCE do nothing
        do_reset();
        step_btn = 1'b1;
        repeat (3) @(negedge clk);
        step_btn = 1'b0;
        repeat (10) @(negedge clk);
        step_btn = 1'b1;
        repeat (3) @(negedge clk);
        step_btn = 1'b0;
        repeat (20) @(negedge clk);
        chk("t2_blank", int'(blank), 1);
        chk("t2_idx", int'(char_idx), 0);

        // 3: manual wrap forward then reverse
        do_reset();
        for (int i = 0; i < 14; i++) press(i, 0);
        chk("t3_idx13", int'(char_idx), 13);
        press(0, 1);
        dir = 1'b1;
        press(13, 1);
        press(12, 0);
        dir = 1'b0;

        // 4: auto rate and a mid-count rate change
        do_reset();
        c = cyc;
        auto_en = 1'b1;
        for (int k = 0; k < 4; k++) push(k, 0, c + 1 + 8 * k);
        wait_to(c + 28);
        rate_sel = 2'd2;
        push(4, 0, c + 29);
        push(5, 0, c + 31);
        push(6, 0, c + 33);
        push(7, 0, c + 35);
        wait_to(c + 36);

        // 5: hold/resume; first press lands on a tick
        do_reset();
        c = cyc;
        auto_en = 1'b1;
        push(0, 0, c + 1);
        push(1, 0, c + 9);
        wait_to(c + 10);
        step_btn = 1'b1;
        wait_to(c + 16);
        chk("t5_hold_pre", int'(holding), 0);
        wait_to(c + 17);
        chk("t5_hold_on", int'(holding), 1);
        chk("t5_idx_frz", int'(char_idx), 1);
        wait_to(c + 18);
        step_btn = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (holding !== 1'b1 || char_idx !== 4'd1) begin
                chk("t5_hold_loop", int'({holding, char_idx}), int'({1'b1, 4'd1}));
            end else begin
                checks++;
            end
        end
        p = cyc;
        push(2, 0, p + 15);
        push(3, 0, p + 23);
        push(4, 0, p + 31);
        step_btn = 1'b1;
        wait_to(p + 6);
        chk("t5_res_pre", int'(holding), 1);
        wait_to(p + 7);
        chk("t5_res_on", int'(holding), 0);
        wait_to(p + 8);
        step_btn = 1'b0;
        wait_to(p + 25);
        step_btn = 1'b1;
        wait_to(p + 31);
        chk("t5_hold2_pre", int'(holding), 0);
        wait_to(p + 32);
        chk("t5_hold2_on", int'(holding), 1);
        chk("t5_idx4", int'(char_idx), 4);
        wait_to(p + 33);
        step_btn = 1'b0;
        wait_to(p + 45);
        auto_en = 1'b0;
        wait_to(p + 46);
        chk("t5_manual", int'(holding), 0);
        chk("t5_man_idx", int'(char_idx), 4);
        wait_to(p + 50);

        // 6: reset mid-run at idx 9
        do_reset();
        c = cyc;
        auto_en = 1'b1;
        for (int k = 0; k < 10; k++) push(k, 0, c + 1 + 8 * k);
        wait_to(c + 75);
        chk("t6_idx9", int'(char_idx), 9);
        rst = 1'b1;
        wait_to(c + 76);
        chk("t6_blank", int'(blank), 1);
        chk("t6_idx", int'(char_idx), 0);
        chk("t6_hold", int'(holding), 0);
        wait_to(c + 80);
        push(0, 0, c + 81);
        rst = 1'b0;
        wait_to(c + 82);
        chk("t6_reentry", int'(blank), 0);

        repeat (4) @(negedge clk);
        auto_en = 1'b0;
        repeat (20) @(negedge clk);
        while (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_load: got none, required idx=%0d wrap=%0d at cyc %0d",
                     e.idx, e.wrp, e.cyc);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_msg_sequencer.md
Name: seg_msg_sequencer

Overview:
- Clocked controller that sequences the seven-segment message datapath.
- Produces the character index, a load strobe and a blanking control for the glyph/segment stage.
- Supports a debounced manual step button, or automatic scrolling at a selectable rate with hold/resume, in either direction.
- Replaces direct button clocking of the display register with a single-clock, synchronous design.

Parameters:
- MSG_LEN, 14, number of characters in message; legal 2..16.
- DEBOUNCE, 20000, consecutive stable cycles required to accept a button level change; min 1.
- TICK_DIV, 1000000, auto-scroll period in clk cycles at rate_sel=0; min 8.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- step_btn  input  1  raw asynchronous step button, active high
- auto_en  input  1  1=auto-scroll, 0=manual step
- dir  input  1  0=forward (idx+1), 1=reverse (idx-1)
- rate_sel  input  2  auto period = TICK_DIV >> rate_sel
- char_idx  output  4  current character index to glyph stage, 0..MSG_LEN-1
- char_load  output  1  one-cycle strobe: glyph stage loads char_idx
- blank  output  1  1=segments forced off
- wrap  output  1  one-cycle pulse coincident with char_load when index wrapped
- holding  output  1  1 while in HOLD state

Behaviour:
- Reset (rst=1 at a clk edge): state=BLANK, char_idx=0, char_load=0, blank=1, wrap=0, holding=0.
  - Also clears the synchronizer, the debounced level, the debounce counter and the prescaler.
  - rst overrides all other inputs.
- Button path:
  - 2-FF synchronizer, then a debounce counter.
  - The debounced level flips only after the synchronized input differs from it for DEBOUNCE consecutive cycles.
  - A debounced 0->1 transition produces a one-cycle step pulse.
  - Exact latency: if step_btn is first sampled 1 at edge E and held, the resulting char_load is high in the cycle after edge E+DEBOUNCE+2.
  - A button held through reset release yields exactly one step after debounce.
  - Glitches shorter than DEBOUNCE cycles produce nothing.
- Prescaler:
  - Runs only in RUN with auto_en=1; otherwise it is held at 0.
  - Tick when count >= period-1, then count returns to 0. Using >= means a rate_sel change to a shorter period ticks on the next cycle.
- State machine:
  - BLANK:
    - On a step pulse or auto_en=1: go to RUN with char_idx=0, char_load=1, blank=0, no advance.
  - RUN, auto_en=0: each step pulse advances the index.
  - RUN, auto_en=1:
    - Each tick advances the index.
    - A step pulse goes to HOLD. The step wins over a same-cycle tick: no advance, prescaler cleared.
  - HOLD:
    - Index frozen, holding=1, no char_load.
    - A step pulse goes to RUN with the prescaler at 0, so the first advance comes a full period later.
    - auto_en=0 goes to RUN (manual mode).
- Advance:
  - Forward: MSG_LEN-1 -> 0 with wrap=1.
  - Reverse: 0 -> MSG_LEN-1 with wrap=1.
  - Otherwise ±1 with wrap=0.
  - char_load=1 for exactly one cycle, in the same cycle char_idx takes its new value.
  - dir is sampled at the advance cycle.
- All outputs are registered; no combinational input-to-output paths.
- char_idx never leaves 0..MSG_LEN-1.

Test Plan (DEBOUNCE=4, TICK_DIV=8, MSG_LEN=14 unless stated):
1. Reset, then hold step_btn high from edge E.
   - Expect char_load=1, char_idx=0, blank=0 in the cycle after E+6.
   - A second clean press expects char_idx=1.
2. Bounce: step_btn high 3 cycles, low 10, high 3, low.
   - Expect no char_load; blank stays 1; state stays BLANK.
3. Manual wrap: at idx 13 with dir=0, press step.
   - Expect idx=0, wrap=1, char_load=1.
   - Then dir=1 and press: expect idx=13, wrap=1.
4. Auto rate: auto_en=1 after reset.
   - Expect idx=0 loaded, then char_load every 8 cycles (1, 2, 3...).
   - Switch rate_sel=2 mid-count: expect a tick the next cycle, then every 2 cycles.
5. Hold/resume: in auto, press step.
   - Expect holding=1 and idx frozen for 30 cycles.
   - Press again: expect holding=0 and the first advance exactly 8 cycles after re-entering RUN.
   - Corner case: a step pulse coinciding with a tick expects HOLD and no advance.
6. Reset mid-run at idx 9 in auto.
   - Expect blank=1, idx=0, holding=0 on the next cycle, and no char_load until re-entry.
